// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a time,
// hands instructions to decode over valid/ready and drops responses made stale by redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Decode handshake: an entry moves when out_valid and out_ready are both high
    // at a rising edge; out_pc/out_inst/out_adel hold steady while out_valid waits.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] reqpc_q, reqpc_d;
    logic        cancel_q, cancel_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_adel_q, out_adel_d;

    logic        pc_aligned;
    logic [31:0] reqpc_next;

    assign pc_aligned = (pc_q[1:0] == 2'b00);
    assign reqpc_next = reqpc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        reqpc_d     = reqpc_q;
        cancel_d    = cancel_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_adel_d  = out_adel_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    // An accepted request still returns data; mark it for discard.
                    if (pc_aligned && inst_addr_ok) begin
                        state_d  = S_WAIT;
                        cancel_d = 1'b1;
                    end
                end else if (!pc_aligned) begin
                    out_valid_d = 1'b1;
                    out_adel_d  = 1'b1;
                    out_inst_d  = 32'h0;
                    out_pc_d    = pc_q;
                    state_d     = S_HOLD;
                end else if (inst_addr_ok) begin
                    state_d = S_WAIT;
                    reqpc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    if (cancel_q || redirect_valid) begin
                        cancel_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        out_inst_d  = inst_rdata;
                        out_pc_d    = reqpc_q;
                        out_adel_d  = 1'b0;
                        out_valid_d = 1'b1;
                        pc_d        = reqpc_next;
                        state_d     = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    cancel_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            reqpc_q     <= 32'h0;
            cancel_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0;
            out_inst_q  <= 32'h0;
            out_adel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            reqpc_q     <= reqpc_d;
            cancel_q    <= cancel_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_adel_q  <= out_adel_d;
        end
    end

    // Request is gated by reset so nothing is issued while the core is held.
    assign inst_req  = rst && (state_q == S_REQ) && pc_aligned;
    assign inst_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;
    assign out_adel  = out_adel_q;
    assign busy      = (state_q == S_WAIT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle vector table, then a memory model with a
// scoreboard of expected deliveries for delay, stall, redirect and wrap cases.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;
    logic        busy;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [64:0] exp_q[$];

    bit          mem_en = 1'b0;
    bit          sb_en  = 1'b0;
    bit          mem_pending = 1'b0;
    bit          mem_stale = 1'b0;
    int          mem_acnt = 0;
    int          mem_dcnt = 0;
    int          addr_delay = 0;
    int          data_delay = 0;
    logic [31:0] mem_addr = 32'h0;

    typedef struct {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_busy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[14];

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_adel        (out_adel),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic ao, input logic dok, input logic [31:0] rd,
                                input logic rdy, input logic req, input logic [31:0] addr,
                                input logic bsy, input logic vld, input logic [31:0] pc,
                                input logic [31:0] inst);
        vec_t v;
        v.addr_ok = ao;  v.data_ok = dok; v.rdata = rd;   v.ready = rdy;
        v.exp_req = req; v.exp_addr = addr; v.exp_busy = bsy; v.exp_valid = vld;
        v.exp_pc = pc;   v.exp_inst = inst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_q.push_back({1'b0, pc, mem_word(pc)});
    endtask

    task automatic sb_pop();
        logic [64:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got pc=%h inst=%h adel=%b expected nothing", out_pc, out_inst, out_adel);
        end else begin
            e = exp_q.pop_front();
            chk("sb_delivery", {63'h0, out_adel, out_pc, out_inst}, {63'h0, e});
        end
    endtask

    // Memory model: drives addr_ok/data_ok for the current cycle from DUT state.
    task automatic mem_cycle();
        if (!mem_en) return;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        chk("busy_is_wait", {127'h0, busy}, {127'h0, mem_pending});
        if (mem_pending) begin
            if (redirect_valid) mem_stale = 1'b1;
            if (mem_dcnt >= data_delay) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_stale ? 32'hDEADBEEF : mem_word(mem_addr);
                mem_pending  = 1'b0;
                mem_stale    = 1'b0;
            end else begin
                mem_dcnt++;
            end
        end else if (inst_req) begin
            if (mem_acnt >= addr_delay) begin
                inst_addr_ok = 1'b1;
                mem_pending  = 1'b1;
                mem_addr     = inst_addr;
                mem_dcnt     = 0;
                mem_acnt     = 0;
                mem_stale    = redirect_valid;
            end else begin
                mem_acnt++;
            end
        end else begin
            mem_acnt = 0;
        end
    endtask

    task automatic step();
        mem_cycle();
        if (sb_en && out_valid && out_ready) sb_pop();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget, input bit rnd_ready);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d entries left expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic bit cond_met(input int sel);
        case (sel)
            0:       return out_valid;
            1:       return busy;
            2:       return inst_req;
            default: return mem_pending && (mem_dcnt >= data_delay);
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input int budget);
        int n = 0;
        while (!cond_met(sel) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!cond_met(sel)) begin
            errors++;
            $display("FAIL %s_timeout: got no event after %0d cycles expected event", name, budget);
        end
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        step();
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        logic [31:0] pcs;

        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata = 32'h0;
        out_ready = 1'b0;

        vecs[0]  = mk(1, 0, 32'h0,        0, 1, 32'hBFC00000, 0, 0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 1, 32'h11111111, 0, 0, 32'hBFC00000, 1, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 32'h0,        1, 0, 32'hBFC00004, 0, 1, 32'hBFC00000, 32'h11111111);
        vecs[3]  = mk(1, 0, 32'h0,        0, 1, 32'hBFC00004, 0, 0, 32'h0,        32'h0);
        vecs[4]  = mk(0, 1, 32'h22222222, 0, 0, 32'hBFC00004, 1, 0, 32'h0,        32'h0);
        vecs[5]  = mk(0, 0, 32'h0,        1, 0, 32'hBFC00008, 0, 1, 32'hBFC00004, 32'h22222222);
        vecs[6]  = mk(0, 1, 32'hEEEEEEEE, 0, 1, 32'hBFC00008, 0, 0, 32'h0,        32'h0);
        vecs[7]  = mk(0, 0, 32'h0,        0, 1, 32'hBFC00008, 0, 0, 32'h0,        32'h0);
        vecs[8]  = mk(1, 0, 32'h0,        0, 1, 32'hBFC00008, 0, 0, 32'h0,        32'h0);
        vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'hBFC00008, 1, 0, 32'h0,        32'h0);
        vecs[10] = mk(0, 1, 32'h33333333, 0, 0, 32'hBFC00008, 1, 0, 32'h0,        32'h0);
        vecs[11] = mk(0, 0, 32'h0,        0, 0, 32'hBFC0000C, 0, 1, 32'hBFC00008, 32'h33333333);
        vecs[12] = mk(0, 0, 32'h0,        1, 0, 32'hBFC0000C, 0, 1, 32'hBFC00008, 32'h33333333);
        vecs[13] = mk(0, 0, 32'h0,        0, 1, 32'hBFC0000C, 0, 0, 32'h0,        32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {59'h0, inst_req, busy, out_valid, out_adel, out_pc, out_inst, inst_addr},
            {59'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hBFC00000});
        rst = 1'b1;
        #1;

        // Cycle-exact vector table
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("vec%0d", i),
                {28'h0, inst_req, inst_addr, busy, out_valid, out_adel,
                 (vecs[i].exp_valid ? out_pc : 32'h0), (vecs[i].exp_valid ? out_inst : 32'h0)},
                {28'h0, vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_busy, vecs[i].exp_valid, 1'b0,
                 vecs[i].exp_pc, vecs[i].exp_inst});
            inst_addr_ok = vecs[i].addr_ok;
            inst_data_ok = vecs[i].data_ok;
            inst_rdata   = vecs[i].rdata;
            out_ready    = vecs[i].ready;
            step();
        end
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        out_ready = 1'b1;

        mem_en = 1'b1;
        sb_en  = 1'b1;

        // Slow memory
        addr_delay = 3;
        data_delay = 2;
        expect_fetch(32'hBFC0000C);
        expect_fetch(32'hBFC00010);
        drain("slow_mem", 60, 1'b0);

        // Decode stall in HOLD
        addr_delay = 0;
        data_delay = 0;
        out_ready = 1'b0;
        expect_fetch(32'hBFC00014);
        expect_fetch(32'hBFC00018);
        wait_for("stall_valid", 0, 20);
        held_pc = out_pc;
        held_inst = out_inst;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_stable", {62'h0, out_valid, inst_req, held_pc, held_inst},
                {62'h0, 1'b1, 1'b0, out_pc, out_inst});
        end
        chk("hold_value", {64'h0, held_pc, held_inst}, {64'h0, 32'hBFC00014, mem_word(32'hBFC00014)});
        out_ready = 1'b1;
        drain("stall", 30, 1'b0);

        // Redirect during WAIT
        data_delay = 3;
        wait_for("c_busy", 1, 20);
        redirect_to(32'h80001000);
        wait_for("c_req", 2, 20);
        chk("c_next_addr", {96'h0, inst_addr}, {96'h0, 32'h80001000});
        data_delay = 0;
        expect_fetch(32'h80001000);
        expect_fetch(32'h80001004);
        drain("redir_wait", 30, 1'b0);

        // Redirect coinciding with addr_ok
        wait_for("d_req", 2, 20);
        redirect_to(32'h80002000);
        wait_for("d_req2", 2, 20);
        chk("d_next_addr", {96'h0, inst_addr}, {96'h0, 32'h80002000});
        expect_fetch(32'h80002000);
        expect_fetch(32'h80002004);
        drain("redir_addr_ok", 30, 1'b0);

        // Redirect coinciding with data_ok
        data_delay = 2;
        wait_for("e_due", 3, 20);
        redirect_to(32'h80003000);
        wait_for("e_req", 2, 20);
        chk("e_next_addr", {96'h0, inst_addr}, {96'h0, 32'h80003000});
        data_delay = 0;
        expect_fetch(32'h80003000);
        expect_fetch(32'h80003004);
        drain("redir_data_ok", 30, 1'b0);

        // Misaligned target, then recovery by redirect
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 32'h80000002, 32'h0});
        redirect_to(32'h80000002);
        for (int n = 0; n < 20 && !out_valid; n++) begin
            if (inst_addr == 32'h80000002 && !busy)
                chk("adel_no_req", {127'h0, inst_req}, {127'h0, 1'b0});
            step();
        end
        chk("adel_valid", {126'h0, out_valid, inst_req}, {126'h0, 1'b1, 1'b0});
        expect_fetch(32'h80000180);
        expect_fetch(32'h80000184);
        out_ready = 1'b1;
        redirect_to(32'h80000180);
        drain("adel", 30, 1'b0);

        // PC wrap
        expect_fetch(32'hFFFFFFFC);
        expect_fetch(32'h00000000);
        expect_fetch(32'h00000004);
        redirect_to(32'hFFFFFFFC);
        drain("wrap", 40, 1'b0);

        // Random delays and decode back-pressure
        pcs = 32'h00000008;
        for (int i = 0; i < 8; i++) begin
            addr_delay = $urandom_range(0, 3);
            data_delay = $urandom_range(0, 3);
            expect_fetch(pcs);
            pcs = pcs + 32'd4;
            drain("random", 80, 1'b1);
        end

        // Asynchronous reset mid-operation
        sb_en = 1'b0;
        out_ready = 1'b0;
        wait_for("rst_valid", 0, 20);
        mem_en = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_reset", {60'h0, out_valid, inst_req, busy, out_adel, inst_addr, out_pc, out_inst},
            {60'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hBFC00000, 32'h0, 32'h0});
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("reset_release", {95'h0, inst_req, inst_addr}, {95'h0, 1'b1, 32'hBFC00000});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
